// File: rtl/irq_pkg.sv
// Shared definitions for the key interrupt front end.
//   irq_state_t   : request FSM states (IDLE / REQ / SERVICE)
//   STATUS_IE_BIT : global interrupt enable bit in CP0 Status
//   STATUS_IM_LSB : Status bit of IM[0]; line k uses bit STATUS_IM_LSB+k
//   CAUSE_IP_LSB  : Cause bit of IP[0]; line k reports at bit CAUSE_IP_LSB+k
//   lowest_onehot : isolates the lowest set bit (fixed priority, index 0 wins)
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    localparam int STATUS_IE_BIT = 0;
    localparam int STATUS_IM_LSB = 8;
    localparam int CAUSE_IP_LSB  = 8;

    function automatic logic [31:0] lowest_onehot(input logic [31:0] v);
        return v & (~v + 32'd1);
    endfunction

endpackage

// File: rtl/key_irq_controller_debounce.sv
// key_debounce: one active-low key line -> synchronised, debounced level and
// a one-cycle press pulse.
//   Clk     : system clock
//   Reset   : asynchronous active-low reset
//   i_raw   : raw key line (0 = pressed), asynchronous to Clk
//   o_level : debounced level (1 = released), 1 out of reset
//   o_press : one-cycle pulse on a debounced 1->0 transition
module key_debounce
    import irq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_vld;
    logic             r_armed;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;

    // The debouncer stays idle until the synchroniser holds a real sample
    // (r_vld) showing the key released. A key held through reset release
    // therefore never reaches the pressed level until it is let go first.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_vld   <= '0;
            r_armed <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_vld   <= {r_vld[0], 1'b1};
            r_press <= 1'b0;
            if (!r_armed) begin
                r_armed <= r_vld[1] & r_sync2;
                r_cnt   <= '0;
            end else if (r_sync2 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                    // Registered alongside the level so the pulse lines up
                    // with the first cycle of the clean pressed level.
                    r_press <= ~r_sync2;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/key_irq_controller.sv
// key_irq_controller: key interrupt front end feeding the core's exception
// logic. Debounces active-low keys, latches pending requests, applies the
// Status IE/IM mask with fixed priority (lowest index wins) and presents a
// single request with its Cause value.
//   Clk, Reset : clock, asynchronous active-low reset
//   i_key      : raw key lines, active-low
//   i_status   : CP0 Status (bit 0 = IE, bit 8+k = IM[k])
//   i_ack      : core took the interrupt (honoured only while requesting)
//   i_eret     : handler returned (honoured only while in service)
//   o_irq      : interrupt request
//   o_cause    : grant one-hot at bits 8+k, zero when idle
//   o_pending  : pending-request bits
// Build option IRQ_LEVEL_EN: pending follows the debounced pressed level and
// is not cleared by i_ack (a held key re-requests after every eret).
module key_irq_controller
    import irq_pkg::*;
#(
    parameter int N_IRQ           = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [N_IRQ-1:0] i_key,
    input  logic [31:0]      i_status,
    input  logic             i_ack,
    input  logic             i_eret,
    output logic             o_irq,
    output logic [31:0]      o_cause,
    output logic [N_IRQ-1:0] o_pending
);

    logic [N_IRQ-1:0] w_level;
    logic [N_IRQ-1:0] w_press;
    logic [N_IRQ-1:0] w_pending;
    logic [N_IRQ-1:0] w_eligible;
    logic [N_IRQ-1:0] w_grant_next;
    logic [N_IRQ-1:0] r_grant;
    irq_state_t       r_state;
    irq_state_t       w_state_next;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .Clk    (Clk),
            .Reset  (Reset),
            .i_raw  (i_key[g]),
            .o_level(w_level[g]),
            .o_press(w_press[g])
        );
    end

`ifdef IRQ_LEVEL_EN
    logic w_unused;
    assign w_unused  = &{1'b0, i_status, w_press};
    assign w_pending = ~w_level;
`else
    logic             w_unused;
    logic [N_IRQ-1:0] w_clr;
    logic [N_IRQ-1:0] r_pending;

    assign w_unused = &{1'b0, i_status, w_level};
    assign w_clr    = ((r_state == REQ) && i_ack) ? r_grant : '0;

    // A press arriving in the same cycle as the acknowledge survives.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_press;
        end
    end

    assign w_pending = r_pending;
`endif

    assign w_eligible   = w_pending & i_status[STATUS_IM_LSB +: N_IRQ]
                        & {N_IRQ{i_status[STATUS_IE_BIT]}};
    assign w_grant_next = N_IRQ'(lowest_onehot(32'(w_eligible)));

    // State register; the grant is captured on the IDLE->REQ transition.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_grant <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == IDLE) && (|w_eligible)) begin
                r_grant <= w_grant_next;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (|w_eligible) w_state_next = REQ;
            end
            REQ: begin
                if (i_ack)                         w_state_next = SERVICE;
                else if (~|(w_eligible & r_grant)) w_state_next = IDLE;
            end
            SERVICE: begin
                if (i_eret) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs decode registered state only, so they are glitch-free and
    // drop asynchronously with Reset.
    always_comb begin
        o_irq   = (r_state == REQ);
        o_cause = '0;
        if (r_state != IDLE) begin
            o_cause[CAUSE_IP_LSB +: N_IRQ] = r_grant;
        end
    end

    assign o_pending = w_pending;

endmodule

// File: tb/tb_key_irq_controller.sv
// Self-checking bench for key_irq_controller (N_IRQ=2, DEBOUNCE_CYCLES=4,
// default edge-latched build). Directed scenarios plus randomized key,
// status, ack and eret traffic checked every cycle against a reference model.
module tb_key_irq_controller;

    localparam int N  = 2;
    localparam int DC = 4;

    logic          Clk;
    logic          Reset;
    logic [N-1:0]  key;
    logic [31:0]   status;
    logic          ack;
    logic          eret;
    logic          irq;
    logic [31:0]   cause;
    logic [N-1:0]  pend;

    int n_checks = 0;
    int n_errors = 0;

    key_irq_controller #(
        .N_IRQ          (N),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .i_key    (key),
        .i_status (status),
        .i_ack    (ack),
        .i_eret   (eret),
        .o_irq    (irq),
        .o_cause  (cause),
        .o_pending(pend)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Debounce: the clean level flips once the last DC synchronised samples
    // (raw input two edges old) all disagree with it, counted only after a
    // released sample has been seen since reset. Requests: mode 0 idle,
    // 1 requesting, 2 in service.
    bit        m_rawq [N][$];
    bit        m_win  [N][$];
    bit [N-1:0] m_clean = '1;
    bit [N-1:0] m_seen  = '0;
    bit [N-1:0] m_pvis  = '0;
    bit [N-1:0] m_pend  = '0;
    int        m_mode  = 0;
    int        m_gnt   = 0;
    bit        chk_en  = 1'b0;

    always @(posedge Clk or negedge Reset) begin : model
        bit [N-1:0] elig;
        bit [N-1:0] nclean;
        bit [N-1:0] npress;
        bit [N-1:0] nclr;
        bit         smp;
        bit         alldiff;
        if (!Reset) begin
            m_clean = '1;
            m_seen  = '0;
            m_pvis  = '0;
            m_pend  = '0;
            m_mode  = 0;
            m_gnt   = 0;
            for (int k = 0; k < N; k++) begin
                m_rawq[k].delete();
                m_win[k].delete();
            end
        end else begin
            elig   = m_pend & status[9:8] & {N{status[0]}};
            nclean = m_clean;
            npress = '0;
            for (int k = 0; k < N; k++) begin
                smp = (m_rawq[k].size() >= 2) ? m_rawq[k][$-1] : 1'b1;
                if (!m_seen[k]) begin
                    if (m_rawq[k].size() >= 2 && smp) m_seen[k] = 1'b1;
                    m_win[k].delete();
                end else begin
                    m_win[k].push_back(smp);
                    if (m_win[k].size() > DC) void'(m_win[k].pop_front());
                    alldiff = (m_win[k].size() == DC);
                    for (int j = 0; j < m_win[k].size(); j++)
                        if (m_win[k][j] == m_clean[k]) alldiff = 1'b0;
                    if (alldiff) begin
                        nclean[k] = ~m_clean[k];
                        npress[k] = m_clean[k];
                        m_win[k].delete();
                    end
                end
                m_rawq[k].push_back(key[k]);
                if (m_rawq[k].size() > 4) void'(m_rawq[k].pop_front());
            end
            nclr = (m_mode == 1 && ack) ? (2'b01 << m_gnt) : 2'b00;
            case (m_mode)
                0: if (elig != 0) begin
                       m_mode = 1;
                       for (int j = N - 1; j >= 0; j--) if (elig[j]) m_gnt = j;
                   end
                1: if (ack) m_mode = 2;
                   else if (!elig[m_gnt]) m_mode = 0;
                default: if (eret) m_mode = 0;
            endcase
            m_pend  = (m_pend & ~nclr) | m_pvis;
            m_pvis  = npress;
            m_clean = nclean;
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("lk_irq", 32'(irq), 32'(m_mode == 1));
            check("lk_cause", cause, (m_mode != 0) ? (32'h100 << m_gnt) : 32'h0);
            check("lk_pending", 32'(pend), 32'(m_pend));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic pulse_ack();
        ack = 1'b1; cyc(1); ack = 1'b0;
    endtask

    task automatic pulse_eret();
        eret = 1'b1; cyc(1); eret = 1'b0;
    endtask

    task automatic wait_irq(input string tag, input int max, output int n);
        n = 0;
        while (!irq && n < max) begin
            cyc(1);
            n++;
        end
        check(tag, 32'(irq), 32'd1);
    endtask

    task automatic count_irq(input int cycles, output int seen);
        seen = 0;
        repeat (cycles) begin
            cyc(1);
            if (irq) seen++;
        end
    endtask

    logic [31:0] stat_tab [0:5];
    int          hold [N];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int seen;
        stat_tab[0] = 32'h301; stat_tab[1] = 32'h201; stat_tab[2] = 32'h101;
        stat_tab[3] = 32'h300; stat_tab[4] = 32'h001; stat_tab[5] = 32'h301;
        Reset = 1'b1; key = '1; status = 32'h301; ack = 1'b0; eret = 1'b0;
        #2 Reset = 1'b0;
        #1;
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_cause", cause, 32'h0);
        check("rst_pending", 32'(pend), 32'd0);
        chk_en = 1'b1;
        repeat (3) @(posedge Clk);
        #2 Reset = 1'b1;
        cyc(6);

        // clean press: request 8 edges after the key edge
        key[0] = 1'b0;
        wait_irq("press_irq", 20, n);
        check("press_latency", 32'(n), 32'd8);
        check("press_cause", cause, 32'h100);
        cyc(2); key[0] = 1'b1;
        pulse_ack();
        check("ack_irq", 32'(irq), 32'd0);
        check("ack_pending", 32'(pend), 32'd0);
        check("ack_cause_held", cause, 32'h100);
        cyc(8);
        pulse_eret();
        check("eret_cause", cause, 32'h0);
        cyc(3);

        // glitch rejection
        key[1] = 1'b0; cyc(3); key[1] = 1'b1;
        count_irq(15, seen);
        check("glitch_irq", 32'(seen), 32'd0);
        check("glitch_pending", 32'(pend), 32'd0);

        // priority
        key = '0;
        wait_irq("prio_irq0", 20, n);
        check("prio_cause0", cause, 32'h100);
        cyc(2); key = '1;
        pulse_ack(); cyc(8); pulse_eret();
        wait_irq("prio_irq1", 5, n);
        check("prio_cause1", cause, 32'h200);
        pulse_ack(); pulse_eret(); cyc(2);

        // masking by IM, then unmask
        status = 32'h201;
        key[0] = 1'b0; cyc(8); key[0] = 1'b1; cyc(8);
        check("mask_irq", 32'(irq), 32'd0);
        check("mask_pending", 32'(pend), 32'd1);
        status = 32'h301; cyc(1);
        check("unmask_irq", 32'(irq), 32'd1);
        check("unmask_cause", cause, 32'h100);
        pulse_ack(); pulse_eret(); cyc(2);

        // IE cleared while requesting
        key[0] = 1'b0;
        wait_irq("ie_irq", 20, n);
        cyc(2); key[0] = 1'b1;
        status = 32'h300; cyc(1);
        check("ie_drop_irq", 32'(irq), 32'd0);
        check("ie_drop_cause", cause, 32'h0);
        check("ie_drop_pending", 32'(pend), 32'd1);
        status = 32'h301;
        wait_irq("ie_restore_irq", 5, n);
        pulse_ack(); cyc(8); pulse_eret(); cyc(2);

        // press pulse collides with ack of the same line
        key[1] = 1'b0;
        wait_irq("coll_irq0", 20, n);
        check("coll_cause0", cause, 32'h200);
        cyc(2); key[1] = 1'b1; cyc(10);
        key[1] = 1'b0; cyc(6);
        pulse_ack();
        check("coll_pending", 32'(pend), 32'd2);
        check("coll_irq_off", 32'(irq), 32'd0);
        key[1] = 1'b1; cyc(8);
        pulse_eret();
        wait_irq("coll_irq1", 5, n);
        check("coll_cause1", cause, 32'h200);
        pulse_ack(); pulse_eret(); cyc(2);

        // reset while requesting, key held through release
        key[0] = 1'b0;
        wait_irq("rstreq_irq", 20, n);
        #2 Reset = 1'b0;
        #1;
        check("rstreq_irq_off", 32'(irq), 32'd0);
        check("rstreq_cause", cause, 32'h0);
        check("rstreq_pending", 32'(pend), 32'd0);
        cyc(2); #2 Reset = 1'b1;
        count_irq(20, seen);
        check("held_no_irq", 32'(seen), 32'd0);
        check("held_pending", 32'(pend), 32'd0);
        key[0] = 1'b1; cyc(10);
        key[0] = 1'b0;
        wait_irq("repress_irq", 20, n);
        check("repress_cause", cause, 32'h100);
        cyc(2); key[0] = 1'b1;
        pulse_ack(); cyc(8); pulse_eret(); cyc(3);

        // randomized traffic against the model
        hold[0] = 0; hold[1] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N; k++) begin
                if (hold[k] == 0) begin
                    key[k]  = ~key[k];
                    hold[k] = int'($urandom_range(1, 12));
                end else begin
                    hold[k]--;
                end
            end
            ack  = (irq && $urandom_range(0, 3) == 0) || ($urandom_range(0, 15) == 0);
            eret = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 39) == 0) status = stat_tab[$urandom_range(0, 5)];
            if (i == 1500) begin
                #2 Reset = 1'b0;
                #4 Reset = 1'b1;
            end
            cyc(1);
        end
        ack = 1'b0; eret = 1'b0; key = '1;
        cyc(20);
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
